// File: rtl/recorrido_pkg.sv
// Shared definitions for the traversal sequencers: FSM encoding,
// position-width derivation and input clamping.
package recorrido_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of a position index; a single bit is still needed when N == 1.
  function automatic int cw_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Positions at or beyond the last LED collapse onto the last LED.
  function automatic int unsigned clamp_pos(input int unsigned v, input int unsigned n);
    return (v >= n) ? (n - 1) : v;
  endfunction

endpackage

// File: rtl/recorrido_der_izq_if.sv
// Control and status bundle of the right-to-left traversal sequencer.
interface recorrido_der_izq_if #(
  parameter int N = 8
) ();
  import recorrido_pkg::*;

  localparam int CW = cw_of(N);

  // Handshake: start is a request that is accepted only while the block is
  // idle (busy=0, done=0); it has no acknowledge other than busy rising on the
  // next cycle. done is a single-cycle completion pulse and needs no ready.
  logic          start;
  logic          pause;
  logic          abort;
  logic          wrap;
  logic [CW-1:0] start_pos;
  logic [CW-1:0] stop_pos;
  logic [N-1:0]  leds;
  logic [CW-1:0] pos;
  logic          busy;
  logic          done;
  state_t        state;

  modport master (
    output start, pause, abort, wrap, start_pos, stop_pos,
    input  leds, pos, busy, done, state
  );

  modport slave (
    input  start, pause, abort, wrap, start_pos, stop_pos,
    output leds, pos, busy, done, state
  );

endinterface

// File: rtl/recorrido_der_izq_divisor_paso.sv
// Pacing counter: spends DIV enabled cycles per position and fires a
// one-cycle step tick on the last of them.
module divisor_paso #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int PW = $clog2(DIV + 1);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] cnt_q, cnt_d;

  // Clear dominates so a cancelled traversal never emits a stale tick.
  always_comb begin
    tick_o = en_i && !clr_i && (cnt_q == LAST);
    cnt_d  = cnt_q;
    if (clr_i || tick_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/recorrido_der_izq.sv
// Right-to-left traversal sequencer: walks a one-hot light from start_pos
// toward bit N-1 (optionally wrapping to 0) and stops at stop_pos.
module recorrido_der_izq
  import recorrido_pkg::*;
#(
  parameter int N   = 8,
  parameter int DIV = 4
) (
  input logic               clk,
  input logic               rst_n,
  recorrido_der_izq_if.slave bus
);

  localparam int CW = cw_of(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [N-1:0]  ONE  = {{(N-1){1'b0}}, 1'b1};

  state_t        state_q, state_d;
  logic [CW-1:0] pos_q, pos_d;
  logic [CW-1:0] stop_q, stop_d;
  logic          wrap_q, wrap_d;
  logic [CW-1:0] start_c, stop_c;
  logic          cnt_en, cnt_clr, tick;

  assign start_c = CW'(clamp_pos(32'(bus.start_pos), 32'(N)));
  assign stop_c  = CW'(clamp_pos(32'(bus.stop_pos), 32'(N)));

  assign cnt_en  = (state_q == RUN) && !bus.pause;
  assign cnt_clr = (state_q != RUN) || bus.abort;

  divisor_paso #(.DIV(DIV)) u_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .tick_o (tick)
  );

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    stop_d  = stop_q;
    wrap_d  = wrap_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          pos_d   = start_c;
          stop_d  = stop_c;
          wrap_d  = bus.wrap;
        end
      end
      RUN: begin
        if (tick) begin
          if ((pos_q == stop_q) || ((pos_q == LAST) && !wrap_q)) begin
            state_d = DONE;
          end else begin
            pos_d = (pos_q == LAST) ? '0 : pos_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Abort wins over start and over a pending step.
    if (bus.abort) begin
      state_d = IDLE;
      pos_d   = pos_q;
      stop_d  = stop_q;
      wrap_d  = wrap_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pos_q   <= '0;
      stop_q  <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      stop_q  <= stop_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.leds  = (state_q == IDLE) ? '0 : (ONE << pos_q);
  assign bus.pos   = pos_q;
  assign bus.busy  = (state_q == RUN);
  assign bus.done  = (state_q == DONE);
  assign bus.state = state_q;

endmodule

// File: tb/tb_recorrido_der_izq.sv
// Bench for recorrido_der_izq (N=8, DIV=4): directed runs with a per-cycle
// expected trace checked by an independent monitor.
module tb_recorrido_der_izq;
  import recorrido_pkg::*;

  localparam int N   = 8;
  localparam int DIV = 4;
  localparam int W   = 13;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  recorrido_der_izq_if #(.N(N)) bus ();

  recorrido_der_izq #(.N(N), .DIV(DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Trace entry: {busy, done, pos, leds}
  logic [W-1:0] exp_q[$];
  int tests_run = 0;
  int tests_failed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] beat(input int p, input bit d);
    logic [7:0] l;
    l = 8'd1 << p;
    return {~d, d, 3'(p), l};
  endfunction

  task automatic push_dwell(input int p, input int n);
    repeat (n) exp_q.push_back(beat(p, 1'b0));
  endtask

  task automatic push_done(input int p);
    exp_q.push_back(beat(p, 1'b1));
  endtask

  // Monitor: every cycle the DUT is active must match the next expected entry.
  always @(negedge clk) begin
    logic [W-1:0] a, e;
    if (rst_n && (bus.busy || bus.done)) begin
      a = {bus.busy, bus.done, bus.pos, bus.leds};
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL unexpected_output: got %0h expected no activity at %0t", a, $time);
      end else begin
        e = exp_q.pop_front();
        chk("trace", 32'(a), 32'(e));
      end
    end
  end

  // Start is presented for one cycle; on return the bench sits in cycle 1.
  task automatic start_run(input int sp, input int ep, input bit w);
    @(posedge clk); #1;
    bus.start     = 1'b1;
    bus.start_pos = 3'(sp);
    bus.stop_pos  = 3'(ep);
    bus.wrap      = w;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("busy_after_start", 32'(bus.busy), 32'd1);
  endtask

  task automatic wait_drain(input int final_pos);
    int i;
    for (i = 0; i < 200; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk); #1;
    end
    chk("drain_timeout", exp_q.size(), 32'd0);
    chk("idle_leds", 32'(bus.leds), 32'd0);
    chk("idle_busy", 32'(bus.busy), 32'd0);
    chk("idle_done", 32'(bus.done), 32'd0);
    chk("idle_pos", 32'(bus.pos), 32'(final_pos));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.start = 1'b0; bus.pause = 1'b0; bus.abort = 1'b0; bus.wrap = 1'b0;
    bus.start_pos = '0; bus.stop_pos = '0;
    #1;
    chk("reset_leds", 32'(bus.leds), 32'd0);
    chk("reset_pos", 32'(bus.pos), 32'd0);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_state", 32'(bus.state), 32'(IDLE));
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // 1: 2 -> 5, no wrap, done at cycle 17
    push_dwell(2, 4); push_dwell(3, 4); push_dwell(4, 4); push_dwell(5, 4); push_done(5);
    start_run(2, 5, 1'b0);
    wait_drain(5);

    // 2: 6 -> 1 wrapping through 7 -> 0
    push_dwell(6, 4); push_dwell(7, 4); push_dwell(0, 4); push_dwell(1, 4); push_done(1);
    start_run(6, 1, 1'b1);
    wait_drain(1);

    // 3: 6 -> 1 without wrap stops at 7, done at cycle 9
    push_dwell(6, 4); push_dwell(7, 4); push_done(7);
    start_run(6, 1, 1'b0);
    wait_drain(7);

    // 4: start == stop, second start in cycle 2 ignored
    push_dwell(0, 4); push_done(0);
    start_run(0, 0, 1'b0);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.start_pos = 3'd5; bus.stop_pos = 3'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_drain(0);

    // 5: pause for 3 cycles while on position 3, done at cycle 20
    push_dwell(2, 4); push_dwell(3, 7); push_dwell(4, 4); push_dwell(5, 4); push_done(5);
    start_run(2, 5, 1'b0);
    repeat (5) begin @(posedge clk); #1; end
    bus.pause = 1'b1;
    chk("paused_busy", 32'(bus.busy), 32'd1);
    repeat (3) begin @(posedge clk); #1; end
    bus.pause = 1'b0;
    wait_drain(5);

    // 6: abort in cycle 6 -> idle in cycle 7, no done
    push_dwell(2, 4); push_dwell(3, 2);
    start_run(2, 5, 1'b0);
    repeat (5) begin @(posedge clk); #1; end
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    chk("abort_leds", 32'(bus.leds), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_state", 32'(bus.state), 32'(IDLE));
    chk("abort_queue", exp_q.size(), 32'd0);
    repeat (3) begin @(posedge clk); #1; end
    chk("abort_no_done", 32'(bus.done), 32'd0);

    // 7: asynchronous reset mid-run, then a fresh run
    push_dwell(2, 4); push_dwell(3, 2);
    start_run(2, 5, 1'b0);
    repeat (6) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("rst_leds", 32'(bus.leds), 32'd0);
    chk("rst_pos", 32'(bus.pos), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_queue", exp_q.size(), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    push_dwell(3, 4); push_done(3);
    start_run(3, 3, 1'b0);
    wait_drain(3);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
